// File: rtl/hdmi_line_buffer.sv
// Ping-pong RGB565 line buffer between the frame source and the HDMI timing generator.
// One bank fills from the write port while the other is read pixel-by-pixel with one-cycle latency.
module hdmi_line_buffer #(
  parameter int LINE_W = 640,
  parameter int ADDR_W = 11,
  parameter int PIX_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  input  logic              wr_sol,
  input  logic [PIX_W-1:0]  wr_data,
  output logic              wr_ready,
  input  logic              rd_line_start,
  input  logic              buffer_rd,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  pixel,
  output logic              line_avail,
  output logic              underrun,
  output logic              overflow
);

  localparam int MEM_AW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LINE_W - 1);
  localparam logic [ADDR_W:0]   LINE_LIM  = (ADDR_W + 1)'(LINE_W);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_READING} bank_t;
  typedef enum logic {WR_IDLE, WR_FILL} wr_t;

  bank_t             r_bank [2];
  bank_t             w_bank_nxt [2];
  wr_t               r_wr_state, w_wr_state_nxt;
  logic [ADDR_W-1:0] r_wr_ptr, w_wr_ptr_nxt;
  logic              r_wr_bank, w_wr_bank_nxt;
  logic              r_wr_ready;
  logic              r_line_avail;
  logic              r_underrun;
  logic              r_overflow;
  logic [PIX_W-1:0]  r_pixel_p1;

  logic [PIX_W-1:0]  r_mem0 [LINE_W];
  logic [PIX_W-1:0]  r_mem1 [LINE_W];

  logic              w_any_empty, w_any_full, w_empty_idx, w_full_idx;
  logic              w_nxt_any_empty, w_nxt_any_full;
  logic              w_rd_valid, w_rd_bank, w_rd_inrange;
  logic              w_mem_we, w_mem_sel;
  logic [MEM_AW-1:0] w_mem_addr;
  logic [MEM_AW-1:0] w_rd_idx;

  assign w_any_empty  = (r_bank[0] == B_EMPTY) || (r_bank[1] == B_EMPTY);
  assign w_any_full   = (r_bank[0] == B_FULL)  || (r_bank[1] == B_FULL);
  assign w_empty_idx  = (r_bank[0] == B_EMPTY) ? 1'b0 : 1'b1;
  assign w_full_idx   = (r_bank[0] == B_FULL)  ? 1'b0 : 1'b1;
  assign w_rd_valid   = (r_bank[0] == B_READING) || (r_bank[1] == B_READING);
  assign w_rd_bank    = (r_bank[1] == B_READING);
  assign w_rd_inrange = ({1'b0, rd_addr} < LINE_LIM);
  assign w_rd_idx     = rd_addr[MEM_AW-1:0];

  // Write FSM and bank bookkeeping; the swap only ever touches FULL/READING banks,
  // the writer only EMPTY/FILLING ones, so both can update the same cycle.
  always_comb begin
    w_bank_nxt[0]  = r_bank[0];
    w_bank_nxt[1]  = r_bank[1];
    w_wr_state_nxt = r_wr_state;
    w_wr_ptr_nxt   = r_wr_ptr;
    w_wr_bank_nxt  = r_wr_bank;
    w_mem_we       = 1'b0;
    w_mem_sel      = r_wr_bank;
    w_mem_addr     = '0;

    case (r_wr_state)
      WR_IDLE: begin
        if (wr_valid && wr_sol && r_wr_ready) begin
          w_bank_nxt[w_empty_idx] = B_FILLING;
          w_wr_bank_nxt  = w_empty_idx;
          w_mem_sel      = w_empty_idx;
          w_mem_we       = 1'b1;
          w_wr_ptr_nxt   = ADDR_W'(1);
          w_wr_state_nxt = WR_FILL;
        end
      end
      WR_FILL: begin
        if (wr_valid) begin
          w_mem_we = 1'b1;
          if (wr_sol) begin
            w_wr_ptr_nxt = ADDR_W'(1);
          end else begin
            w_mem_addr = r_wr_ptr[MEM_AW-1:0];
            if (r_wr_ptr == LAST_ADDR) begin
              w_bank_nxt[r_wr_bank] = B_FULL;
              w_wr_ptr_nxt   = '0;
              w_wr_state_nxt = WR_IDLE;
            end else begin
              w_wr_ptr_nxt = r_wr_ptr + ADDR_W'(1);
            end
          end
        end
      end
      default: w_wr_state_nxt = WR_IDLE;
    endcase

    if (rd_line_start && w_any_full) begin
      w_bank_nxt[w_full_idx] = B_READING;
      if (r_bank[~w_full_idx] == B_READING)
        w_bank_nxt[~w_full_idx] = B_EMPTY;
    end
  end

  assign w_nxt_any_empty = (w_bank_nxt[0] == B_EMPTY) || (w_bank_nxt[1] == B_EMPTY);
  assign w_nxt_any_full  = (w_bank_nxt[0] == B_FULL)  || (w_bank_nxt[1] == B_FULL);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bank[0]    <= B_EMPTY;
      r_bank[1]    <= B_EMPTY;
      r_wr_state   <= WR_IDLE;
      r_wr_ptr     <= '0;
      r_wr_bank    <= 1'b0;
      r_wr_ready   <= 1'b0;
      r_line_avail <= 1'b0;
      r_underrun   <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_bank[0]    <= w_bank_nxt[0];
      r_bank[1]    <= w_bank_nxt[1];
      r_wr_state   <= w_wr_state_nxt;
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_wr_bank    <= w_wr_bank_nxt;
      r_wr_ready   <= (w_wr_state_nxt == WR_FILL) || w_nxt_any_empty;
      r_line_avail <= w_nxt_any_full;
      r_underrun   <= rd_line_start && !w_any_full;
      r_overflow   <= wr_valid && !r_wr_ready;
    end
  end

  // Storage write port (data path, no reset)
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      if (w_mem_sel)
        r_mem1[w_mem_addr] <= wr_data;
      else
        r_mem0[w_mem_addr] <= wr_data;
    end
  end

  // Read stage p1: registered pixel, zero whenever there is nothing valid to show
  always_ff @(posedge clk) begin
    if (reset)
      r_pixel_p1 <= '0;
    else if (buffer_rd && w_rd_valid && w_rd_inrange)
      r_pixel_p1 <= w_rd_bank ? r_mem1[w_rd_idx] : r_mem0[w_rd_idx];
    else
      r_pixel_p1 <= '0;
  end

  assign wr_ready   = r_wr_ready;
  assign pixel      = r_pixel_p1;
  assign line_avail = r_line_avail;
  assign underrun   = r_underrun;
  assign overflow   = r_overflow;

endmodule

// File: doc/hdmi_line_buffer.md
Name: hdmi_line_buffer

Overview:
- Ping-pong line buffer that sits directly upstream of the HDMI RGB video timing generator.
- Accepts one RGB565 video line at a time from the frame source (camera/SDRAM reader) on a valid/ready write port.
- Serves the timing generator's per-pixel reads from the other bank, with one-cycle registered latency.
- Lines are swapped at each start of active video line; underrun and overflow are flagged.

Parameters:
- LINE_W, 640, pixels per line and the depth of each bank.
- ADDR_W, 11, read/write address width; must satisfy 2^ADDR_W >= LINE_W.
- PIX_W, 16, pixel width (RGB565).

Ports:
- Interface: one clock; reset is synchronous and active-high.
- clk  in  1  pixel clock, shared by the write and read sides.
- reset  in  1  synchronous active-high reset.
- wr_valid  in  1  write pixel valid.
- wr_sol  in  1  start of line; qualified by wr_valid and marks pixel 0 of a line.
- wr_data  in  PIX_W  RGB565 pixel.
- wr_ready  out  1  buffer can accept a pixel this cycle.
- rd_line_start  in  1  one-cycle pulse before each active line; swaps the banks.
- buffer_rd  in  1  read enable, high during active pixels.
- rd_addr  in  ADDR_W  pixel index within the line.
- pixel  out  PIX_W  read data.
- line_avail  out  1  a complete line is waiting (a bank is FULL).
- underrun  out  1  one-cycle pulse.
- overflow  out  1  one-cycle pulse.

Behaviour:
- Storage: two banks of LINE_W x PIX_W each. Each bank has a state: EMPTY, FILLING, FULL or READING. At most one bank is READING at a time.
- Reset: both banks EMPTY, no READING bank, write pointer 0, write FSM in IDLE. Outputs after reset: pixel=0, wr_ready=0 until the next cycle, line_avail=0, underrun=0, overflow=0.
- Write FSM, IDLE: wr_ready=1 if any bank is EMPTY. A beat with wr_valid & wr_sol & wr_ready does the following:
  - claims the lowest-index EMPTY bank and marks it FILLING;
  - writes the pixel at address 0;
  - sets the write pointer to 1;
  - moves the FSM to FILL.
- Write FSM, IDLE, no wr_sol: wr_valid without wr_sol is discarded with no flag (line alignment is not yet known).
- Write FSM, FILL: wr_ready=1. Each wr_valid writes the pixel at the write pointer and increments the pointer. On the beat that writes address LINE_W-1, the bank becomes FULL and the FSM returns to IDLE.
- Write FSM, FILL with wr_sol: the current fill is abandoned. The pixel is written at address 0, the pointer becomes 1, and the bank stays FILLING.
- Write FSM, no EMPTY bank: wr_ready=0. A wr_valid beat while wr_ready=0 is dropped and overflow pulses for 1 cycle.
- Read swap: on rd_line_start the bank states are sampled as registered at the start of that cycle.
  - If a bank is FULL: it becomes READING and the previously READING bank (if any) becomes EMPTY.
  - If no bank is FULL: there is no swap, the current READING bank is re-read (line repeat), and underrun pulses for 1 cycle.
- Simultaneous completion and swap: a bank that completes on the same cycle as rd_line_start is not yet FULL, so an underrun is flagged. It is consumed at the next rd_line_start.
- Read data, latency exactly 1 clock: pixel <= mem[read_bank][rd_addr] when buffer_rd=1, a READING bank exists and rd_addr < LINE_W.
  - Otherwise pixel <= 0. This covers out-of-range addresses, buffer_rd=0 and no READING bank.
- Writes never target the READING bank, so there is no read/write collision within a bank.
- line_avail: registered; equals 1 while any bank is FULL.
- Reset mid-line: all state is cleared on the next edge and any partial line is lost. The next valid line must begin with wr_sol.

Test Plan:
- Reset, then 640 beats of wr_valid with wr_data=addr and wr_sol on beat 0 -> line_avail=1 one cycle after the last beat. Then pulse rd_line_start, buffer_rd=1, rd_addr=0..639 -> pixel equals the address one cycle later.
- Fill bank A, swap, fill bank B while reading A -> wr_ready stays 1 throughout. Second swap -> pixel data is from B and A returns to EMPTY.
- rd_line_start with no FULL bank -> underrun pulses once and the previous line is re-read unchanged.
- Both banks occupied (FULL + READING), drive wr_valid -> wr_ready=0, overflow pulses each dropped beat, and stored data is unchanged.
- wr_sol asserted at write pointer 300 -> fill restarts at address 0, and the line completes 640 beats after that wr_sol.
- rd_addr=700 with buffer_rd=1, then buffer_rd=0 -> pixel=0 in both cases. rd_line_start on the same cycle as the final write beat -> underrun=1, and the bank is taken at the next start.
